regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core writeback vs. one out-of-order
// multi-cycle unit, with a result FIFO, starvation guard and RAW scoreboard.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   core_wEn/wreg/wdata     single-cycle core writeback request (0-latency)
//   ext_valid/ready         multi-cycle result handshake (ready = not full)
//   ext_wreg/wdata          multi-cycle result destination and data
//   issue_en/issue_reg      marks a multi-cycle destination as pending
//   rs1, rs2, hazard        decode sources; hazard if either is pending
//   stall_req               core must hold its writeback this cycle
//   wEn/write_reg/write_data  regFile write port

module regfile_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_wEn,
    input  logic [4:0]  core_wreg,
    input  logic [31:0] core_wdata,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [4:0]  ext_wreg,
    input  logic [31:0] ext_wdata,
    input  logic        issue_en,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic        stall_req,
    output logic        wEn,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    WAIT_LIM = 4'(MAX_WAIT);

    // Result FIFO storage; data is not reset, only the pointers are.
    logic [4:0]    fifo_reg  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [3:0]    wait_cnt;
    logic [3:0]    wait_inc;
    logic [3:0]    wait_next;
    logic          stall_q;
    logic          stall_next;

    logic [31:0]   pending;
    logic [31:0]   pending_next;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          grant_core;
    logic          grant_fifo;
    logic [4:0]    head_reg;
    logic [31:0]   head_data;
    logic [4:0]    g_reg;
    logic [31:0]   g_data;

    assign fifo_empty = (count == '0);
    assign head_reg   = fifo_reg[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Ready depends only on registered count, so a same-cycle pop
    // never feeds back into the producer handshake.
    assign ext_ready = !reset && (count != FULL_CNT);
    assign push      = ext_valid && ext_ready;
    assign pop       = grant_fifo;
    assign stall_req = stall_q;

    // Forced grant first, then core, then opportunistic FIFO drain.
    always_comb begin
        grant_core = 1'b0;
        grant_fifo = 1'b0;
        if (!reset) begin
            if (stall_q && !fifo_empty) begin
                grant_fifo = 1'b1;
            end else if (core_wEn) begin
                grant_core = 1'b1;
            end else if (!fifo_empty) begin
                grant_fifo = 1'b1;
            end
        end
    end

    always_comb begin
        g_reg  = 5'd0;
        g_data = 32'd0;
        if (grant_fifo) begin
            g_reg  = head_reg;
            g_data = head_data;
        end else if (grant_core) begin
            g_reg  = core_wreg;
            g_data = core_wdata;
        end
    end

    // x0 grants still consume the slot but never reach the regFile.
    assign wEn        = (grant_fifo || grant_core) && (g_reg != 5'd0);
    assign write_reg  = g_reg;
    assign write_data = g_data;

    // Starvation guard: stall is raised on the edge where the head
    // has waited MAX_WAIT cycles, forcing a grant on the next cycle.
    always_comb begin
        wait_inc   = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
        wait_next  = 4'd0;
        stall_next = 1'b0;
        if (!fifo_empty && !pop) begin
            wait_next  = wait_inc;
            stall_next = stall_q || (wait_inc >= WAIT_LIM);
        end
    end

    // Scoreboard: a same-cycle issue of the retiring register wins.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_en && (issue_reg != 5'd0)) begin
            set_mask = 32'd1 << issue_reg;
        end
        if (pop) begin
            clr_mask = 32'd1 << head_reg;
        end
        pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    assign hazard = !reset && (pending[rs1] || pending[rs2]);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= ext_wreg;
            fifo_data[wr_ptr] <= ext_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= 4'd0;
            stall_q  <= 1'b0;
            pending  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            wait_cnt <= wait_next;
            stall_q  <= stall_next;
            pending  <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, expected regFile
// writes queued by the driver and checked in order by a monitor.

module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        core_wEn;
    logic [4:0]  core_wreg;
    logic [31:0] core_wdata;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_wreg;
    logic [31:0] ext_wdata;
    logic        issue_en;
    logic [4:0]  issue_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        stall_req;
    logic        wEn;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks;
    int  failures;

    regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .core_wEn   (core_wEn),
        .core_wreg  (core_wreg),
        .core_wdata (core_wdata),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .ext_wreg   (ext_wreg),
        .ext_wdata  (ext_wdata),
        .issue_en   (issue_en),
        .issue_reg  (issue_reg),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .stall_req  (stall_req),
        .wEn        (wEn),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic exp_w(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{r: r, d: d});
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Monitor: every regFile write must match the next expected entry.
    always @(negedge clock) begin
        if (wEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got reg %0d data %h expected none @%0t",
                         write_reg, write_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_reg", 32'(write_reg), 32'(mon_e.r));
                chk("wb_data", write_data, mon_e.d);
            end
        end
    end

    initial begin
        clock      = 1'b0;
        reset      = 1'b1;
        core_wEn   = 1'b0;
        core_wreg  = 5'd0;
        core_wdata = 32'd0;
        ext_valid  = 1'b0;
        ext_wreg   = 5'd0;
        ext_wdata  = 32'd0;
        issue_en   = 1'b0;
        issue_reg  = 5'd0;
        rs1        = 5'd0;
        rs2        = 5'd0;
        checks     = 0;
        failures   = 0;

        next_cycle();
        next_cycle();
        mid();
        chk("rst_wEn", 32'(wEn), 32'd0);
        chk("rst_ext_ready", 32'(ext_ready), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        next_cycle();
        reset = 1'b0;
        mid();
        chk("post_rst_ready", 32'(ext_ready), 32'd1);
        chk("post_rst_stall", 32'(stall_req), 32'd0);
        chk("post_rst_wEn", 32'(wEn), 32'd0);

        // Core only: same-cycle write.
        next_cycle();
        core_wEn   = 1'b1;
        core_wreg  = 5'd2;
        core_wdata = 32'h6620_8C33;
        exp_w(5'd2, 32'h6620_8C33);
        mid();
        chk("core_wEn", 32'(wEn), 32'd1);
        chk("core_ready", 32'(ext_ready), 32'd1);
        next_cycle();
        core_wEn = 1'b0;
        mid();
        chk("idle_wEn", 32'(wEn), 32'd0);
        chk("idle_reg", 32'(write_reg), 32'd0);
        chk("idle_data", write_data, 32'd0);

        // Ext only: one cycle latency.
        next_cycle();
        ext_valid = 1'b1;
        ext_wreg  = 5'd6;
        ext_wdata = 32'd4;
        exp_w(5'd6, 32'd4);
        mid();
        chk("ext_push_cycle_wEn", 32'(wEn), 32'd0);
        next_cycle();
        ext_valid = 1'b0;
        mid();
        chk("ext_write_wEn", 32'(wEn), 32'd1);
        chk("ext_ready_1", 32'(ext_ready), 32'd1);
        next_cycle();
        mid();
        chk("ext_after_wEn", 32'(wEn), 32'd0);

        // Contention: head waits 4 cycles, then a forced grant.
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            core_wEn   = 1'b1;
            core_wreg  = 5'd3;
            core_wdata = 32'd100 + 32'(i);
            ext_valid  = (i == 0);
            ext_wreg   = 5'd20;
            ext_wdata  = 32'd9;
            if (i == 5) exp_w(5'd20, 32'd9);
            else exp_w(5'd3, 32'd100 + 32'(i));
            mid();
            chk($sformatf("stall_c%0d", i), 32'(stall_req),
                32'(i == 5));
        end
        next_cycle();
        core_wEn  = 1'b0;
        ext_valid = 1'b0;

        // Scoreboard.
        issue_en  = 1'b1;
        issue_reg = 5'd7;
        rs1       = 5'd7;
        mid();
        chk("haz_issue_cycle", 32'(hazard), 32'd0);
        next_cycle();
        issue_en  = 1'b0;
        ext_valid = 1'b1;
        ext_wreg  = 5'd7;
        ext_wdata = 32'h77;
        exp_w(5'd7, 32'h77);
        mid();
        chk("haz_set", 32'(hazard), 32'd1);
        next_cycle();
        ext_valid = 1'b0;
        mid();
        chk("haz_grant_cycle", 32'(hazard), 32'd1);
        next_cycle();
        issue_en  = 1'b1;
        issue_reg = 5'd7;
        mid();
        chk("haz_cleared", 32'(hazard), 32'd0);
        next_cycle();
        issue_en  = 1'b0;
        ext_valid = 1'b1;
        ext_wdata = 32'h78;
        exp_w(5'd7, 32'h78);
        next_cycle();
        ext_valid = 1'b0;
        issue_en  = 1'b1;
        mid();
        chk("haz_setclr_cycle", 32'(hazard), 32'd1);
        next_cycle();
        issue_en  = 1'b0;
        ext_valid = 1'b1;
        ext_wdata = 32'h79;
        exp_w(5'd7, 32'h79);
        mid();
        chk("haz_set_wins", 32'(hazard), 32'd1);
        next_cycle();
        ext_valid = 1'b0;
        next_cycle();
        mid();
        chk("haz_final_clear", 32'(hazard), 32'd0);

        // Full FIFO and x0 entry.
        next_cycle();
        rs1        = 5'd0;
        rs2        = 5'd9;
        issue_en   = 1'b1;
        issue_reg  = 5'd9;
        core_wEn   = 1'b1;
        core_wreg  = 5'd4;
        core_wdata = 32'd200;
        ext_valid  = 1'b1;
        ext_wreg   = 5'd0;
        ext_wdata  = 32'hAA;
        exp_w(5'd4, 32'd200);
        mid();
        chk("full_rdy0", 32'(ext_ready), 32'd1);
        next_cycle();
        issue_en   = 1'b0;
        core_wdata = 32'd201;
        ext_wreg   = 5'd11;
        ext_wdata  = 32'hBB;
        exp_w(5'd4, 32'd201);
        mid();
        chk("full_rdy1", 32'(ext_ready), 32'd1);
        chk("haz_rs2", 32'(hazard), 32'd1);
        next_cycle();
        ext_valid  = 1'b0;
        core_wdata = 32'd202;
        exp_w(5'd4, 32'd202);
        mid();
        chk("full_rdy2", 32'(ext_ready), 32'd0);
        next_cycle();
        core_wEn = 1'b0;
        mid();
        chk("x0_pop_wEn", 32'(wEn), 32'd0);
        chk("pop_no_ready", 32'(ext_ready), 32'd0);
        chk("x0_haz_kept", 32'(hazard), 32'd1);
        next_cycle();
        exp_w(5'd11, 32'hBB);
        mid();
        chk("after_x0_ready", 32'(ext_ready), 32'd1);
        chk("after_x0_haz", 32'(hazard), 32'd1);
        next_cycle();
        core_wEn   = 1'b1;
        core_wreg  = 5'd0;
        core_wdata = 32'h55;
        mid();
        chk("core_x0_wEn", 32'(wEn), 32'd0);
        next_cycle();
        core_wEn = 1'b0;

        // Reset mid-operation.
        core_wEn   = 1'b1;
        core_wreg  = 5'd5;
        core_wdata = 32'd300;
        ext_valid  = 1'b1;
        ext_wreg   = 5'd13;
        ext_wdata  = 32'd1;
        issue_en   = 1'b1;
        issue_reg  = 5'd12;
        rs1        = 5'd12;
        exp_w(5'd5, 32'd300);
        next_cycle();
        core_wdata = 32'd301;
        ext_wreg   = 5'd14;
        ext_wdata  = 32'd2;
        issue_en   = 1'b0;
        exp_w(5'd5, 32'd301);
        mid();
        chk("pre_rst_haz", 32'(hazard), 32'd1);
        next_cycle();
        reset      = 1'b1;
        core_wdata = 32'd302;
        ext_wreg   = 5'd15;
        ext_wdata  = 32'd3;
        mid();
        chk("mid_rst_wEn", 32'(wEn), 32'd0);
        chk("mid_rst_reg", 32'(write_reg), 32'd0);
        chk("mid_rst_data", write_data, 32'd0);
        chk("mid_rst_ready", 32'(ext_ready), 32'd0);
        chk("mid_rst_haz", 32'(hazard), 32'd0);
        next_cycle();
        reset     = 1'b0;
        core_wEn  = 1'b0;
        ext_valid = 1'b0;
        mid();
        chk("after_rst_wEn", 32'(wEn), 32'd0);
        chk("after_rst_haz", 32'(hazard), 32'd0);
        chk("after_rst_ready", 32'(ext_ready), 32'd1);
        chk("after_rst_stall", 32'(stall_req), 32'd0);
        next_cycle();
        mid();
        chk("after_rst_empty", 32'(wEn), 32'd0);

        next_cycle();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
